regfile_write_arbiter: RTL and testbench

Shares the single write port of the register bank (built from the `REGISTER_FLIP_FLOP` cells) between two requesters: core writeback (port 0) and the debug/loader path (port 1). It grants one requester at a time with a valid/ready handshake, supports locked bursts, and decodes the winning address into a registered one-hot `ClockEnable` vector and write data for the bank. Register x0 is hardwired to zero and is never enabled.

---
 rtl/regfile_arb_pkg.sv | 26 ++
 rtl/regfile_wr_decoder.sv | 25 ++
 rtl/regfile_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared encodings for the register-bank write arbiter.
// Optional feature macro: REGFILE_ARB_ROUND_ROBIN_EN (see top level).
package regfile_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_DBG  = 1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRANT0 = ST_GRANT0,
    GRANT1 = ST_GRANT1
  } arb_state_e;

  localparam int unsigned CNT_W = 4;

  function automatic logic port_of(
    input arb_state_e st
  );
    return (st == GRANT1) ? PORT_DBG[0] : PORT_CORE[0];
  endfunction

endpackage

// File: rtl/regfile_wr_decoder.sv
// regfile_wr_decoder: address to one-hot ClockEnable, x0 never enabled,
// out-of-range addresses flagged and suppressed.
module regfile_wr_decoder #(
  parameter int NrOfRegs = 32,
  parameter int AddrBits = 5
) (
  input  logic [AddrBits-1:0] addr_i,
  output logic [NrOfRegs-1:0] en_o,
  output logic                oor_o
);

  localparam logic [AddrBits:0] Limit =
    (AddrBits+1)'(NrOfRegs);

  assign oor_o = {1'b0, addr_i} >= Limit;

  // Bit 0 is left at zero: x0 is hardwired.
  always_comb begin
    en_o = '0;
    for (int i = 1; i < NrOfRegs; i++) begin
      en_o[i] = (addr_i == AddrBits'(i));
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-port arbiter for the register bank write port.
// Define REGFILE_ARB_ROUND_ROBIN_EN for round-robin ties (else port 0 wins).
import regfile_arb_pkg::*;

module regfile_write_arbiter #(
  parameter int NrOfBits = 32,
  parameter int NrOfRegs = 32,
  parameter int AddrBits = 5,
  parameter int MaxBurst = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                Req0Valid,
  input  logic                Req0Lock,
  input  logic [AddrBits-1:0] Req0Addr,
  input  logic [NrOfBits-1:0] Req0Data,
  output logic                Req0Ready,
  input  logic                Req1Valid,
  input  logic                Req1Lock,
  input  logic [AddrBits-1:0] Req1Addr,
  input  logic [NrOfBits-1:0] Req1Data,
  output logic                Req1Ready,
  output logic [NrOfRegs-1:0] WrEnable,
  output logic [NrOfBits-1:0] WrData,
  output logic                Busy,
  output logic                AddrError
);

  localparam logic [CNT_W-1:0] MaxCnt =
    CNT_W'(MaxBurst);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  logic                sel_valid;
  logic                sel_lock;
  logic [AddrBits-1:0] sel_addr;
  logic [NrOfBits-1:0] sel_data;
  logic                acc;
  logic                pick1;

  logic [NrOfRegs-1:0] dec_en;
  logic                dec_oor;

  logic [NrOfRegs-1:0] wr_en_q;
  logic [NrOfRegs-1:0] wr_en_d;
  logic [NrOfBits-1:0] wr_data_q;
  logic [NrOfBits-1:0] wr_data_d;
  logic                addr_err_q;
  logic                addr_err_d;

  assign Req0Ready = (state_q == GRANT0);
  assign Req1Ready = (state_q == GRANT1);
  assign Busy      = (state_q != IDLE);
  assign WrEnable  = wr_en_q;
  assign WrData    = wr_data_q;
  assign AddrError = addr_err_q;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    sel_valid = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = Req0Addr;
    sel_data  = Req0Data;
    unique case (1'b1)
      Req0Ready: begin
        sel_valid = Req0Valid;
        sel_lock  = Req0Lock;
      end
      Req1Ready: begin
        sel_valid = Req1Valid;
        sel_lock  = Req1Lock;
        sel_addr  = Req1Addr;
        sel_data  = Req1Data;
      end
      default: ;
    endcase
  end

  assign acc = sel_valid & Tick;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic last_q;
  assign pick1 = Req1Valid & (~Req0Valid | ~last_q);
`else
  assign pick1 = Req1Valid & ~Req0Valid;
`endif

  regfile_wr_decoder #(
    .NrOfRegs (NrOfRegs),
    .AddrBits (AddrBits)
  ) u_dec (
    .addr_i (sel_addr),
    .en_o   (dec_en),
    .oor_o  (dec_oor)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else if (Tick) begin
      unique case (state_q)
        IDLE: begin
          if (Req0Valid | Req1Valid) begin
            state_q <= pick1 ? GRANT1 : GRANT0;
          end
        end
        GRANT0, GRANT1: begin
          if (!sel_valid) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (sel_lock &&
                       (cnt_inc < MaxCnt)) begin
            cnt_q   <= cnt_inc;
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            last_q  <= port_of(state_q);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Enable is a one-cycle pulse; data is held between beats.
  always_comb begin
    wr_en_d    = acc ? dec_en : '0;
    wr_data_d  = acc ? sel_data : wr_data_q;
    addr_err_d = addr_err_q | (acc & dec_oor);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus with queued expectations,
// popped by monitors for grants and bank writes.
module tb_regfile_write_arbiter;

  localparam int NB = 32;
  localparam int NR = 32;
  localparam int AB = 6;
  localparam int MB = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Tick;
  logic          Req0Valid, Req0Lock, Req0Ready;
  logic          Req1Valid, Req1Lock, Req1Ready;
  logic [AB-1:0] Req0Addr, Req1Addr;
  logic [NB-1:0] Req0Data, Req1Data;
  logic [NR-1:0] WrEnable;
  logic [NB-1:0] WrData;
  logic          Busy;
  logic          AddrError;

  regfile_write_arbiter #(
    .NrOfBits (NB),
    .NrOfRegs (NR),
    .AddrBits (AB),
    .MaxBurst (MB)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Tick      (Tick),
    .Req0Valid (Req0Valid),
    .Req0Lock  (Req0Lock),
    .Req0Addr  (Req0Addr),
    .Req0Data  (Req0Data),
    .Req0Ready (Req0Ready),
    .Req1Valid (Req1Valid),
    .Req1Lock  (Req1Lock),
    .Req1Addr  (Req1Addr),
    .Req1Data  (Req1Data),
    .Req1Ready (Req1Ready),
    .WrEnable  (WrEnable),
    .WrData    (WrData),
    .Busy      (Busy),
    .AddrError (AddrError)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] en;
    logic [31:0] data;
  } wr_t;

  wr_t wq[$];
  int  gq[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic exp_wr(input logic [31:0] en,
                        input logic [31:0] d);
    wr_t w;
    w.en   = en;
    w.data = d;
    wq.push_back(w);
  endtask

  wr_t  mw;
  int   mp;
  logic a0, a1;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (WrEnable != '0) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", WrEnable, 32'h0);
        end else begin
          mw = wq.pop_front();
          chk("wr_en", WrEnable, mw.en);
          chk("wr_data", WrData, mw.data);
        end
      end
      a0 = Req0Valid & Req0Ready & Tick;
      a1 = Req1Valid & Req1Ready & Tick;
      if (a0 | a1) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", {30'b0, a1, a0}, 32'h0);
        end else begin
          mp = gq.pop_front();
          chk("grant_port", {30'b0, a1, a0},
              (mp == 1) ? 32'h2 : 32'h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int          rr_seq [4];
  logic [31:0] burst_en [6];

  initial begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    rr_seq = '{1, 0, 1, 0};
`else
    rr_seq = '{0, 0, 0, 0};
`endif
    burst_en = '{32'h100, 32'h200, 32'h400,
                 32'h800, 32'h1000, 32'h2000};

    Reset = 1'b1; Tick = 1'b1;
    Req0Valid = 0; Req0Lock = 0;
    Req0Addr = '0; Req0Data = '0;
    Req1Valid = 0; Req1Lock = 0;
    Req1Addr = '0; Req1Data = '0;
    repeat (3) cyc();
    chk("rst_wren", WrEnable, 32'h0);
    chk("rst_wrdata", WrData, 32'h0);
    chk("rst_busy", Busy, 0);
    chk("rst_adderr", AddrError, 0);
    chk("rst_rdy0", Req0Ready, 0);
    chk("rst_rdy1", Req1Ready, 0);
    Reset = 1'b0;

    gq.push_back(0);
    exp_wr(32'h20, 32'hDEADBEEF);
    Req0Valid = 1; Req0Addr = 5;
    Req0Data = 32'hDEADBEEF;
    cyc();
    chk("sw_rdy0", Req0Ready, 1);
    chk("sw_rdy1", Req1Ready, 0);
    chk("sw_busy", Busy, 1);
    chk("sw_en_early", WrEnable, 32'h0);
    cyc();
    Req0Valid = 0;
    chk("sw_en", WrEnable, 32'h20);
    chk("sw_data", WrData, 32'hDEADBEEF);
    chk("sw_rdy_off", Req0Ready, 0);
    cyc();
    chk("sw_pulse", WrEnable, 32'h0);
    chk("sw_hold", WrData, 32'hDEADBEEF);

    for (int k = 0; k < 4; k++) begin
      gq.push_back(rr_seq[k]);
      if (rr_seq[k] == 1) exp_wr(32'h4, 32'hB1);
      else exp_wr(32'h2, 32'hA0);
    end
    Req0Valid = 1; Req0Addr = 1; Req0Data = 32'hA0;
    Req1Valid = 1; Req1Addr = 2; Req1Data = 32'hB1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr_busy", Busy, (k % 2 == 0) ? 1 : 0);
    end
    Req0Valid = 0; Req1Valid = 0;

    for (int i = 0; i < 4; i++) gq.push_back(1);
    gq.push_back(0);
    gq.push_back(1); gq.push_back(1);
    for (int i = 0; i < 4; i++)
      exp_wr(burst_en[i], 32'h1000_0000 | i);
    exp_wr(32'h80, 32'h0700_0000);
    exp_wr(burst_en[4], 32'h1000_0004);
    exp_wr(burst_en[5], 32'h1000_0005);
    Req1Valid = 1; Req1Lock = 1;
    Req1Addr = 8; Req1Data = 32'h1000_0000;
    cyc();
    Req0Valid = 1; Req0Addr = 7;
    Req0Data = 32'h0700_0000;
    for (int i = 0; i < 4; i++) begin
      chk("burst_rdy1", Req1Ready, 1);
      cyc();
      Req1Addr = AB'(9 + i);
      Req1Data = 32'h1000_0000 | (i + 1);
    end
    chk("burst_gap_busy", Busy, 0);
    chk("burst_gap_rdy1", Req1Ready, 0);
    cyc();
    chk("burst_then_p0", Req0Ready, 1);
    cyc();
    Req0Valid = 0;
    cyc();
    chk("burst_resume", Req1Ready, 1);
    cyc();
    Req1Addr = 13; Req1Data = 32'h1000_0005;
    Req1Lock = 0;
    cyc();
    Req1Valid = 0;
    repeat (2) cyc();

    gq.push_back(0);
    Req0Valid = 1; Req0Addr = 0; Req0Data = 32'h55;
    cyc(); cyc();
    Req0Valid = 0;
    chk("x0_en", WrEnable, 32'h0);
    chk("x0_data", WrData, 32'h55);
    chk("x0_err", AddrError, 0);
    gq.push_back(0);
    Req0Valid = 1; Req0Addr = 40; Req0Data = 32'h66;
    cyc(); cyc();
    Req0Valid = 0;
    chk("oor_en", WrEnable, 32'h0);
    chk("oor_data", WrData, 32'h66);
    chk("oor_err", AddrError, 1);
    repeat (3) cyc();
    chk("oor_sticky", AddrError, 1);

    gq.push_back(0);
    exp_wr(32'h200, 32'h77);
    Req0Valid = 1; Req0Addr = 9; Req0Data = 32'h77;
    cyc();
    Tick = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("tg_rdy_held", Req0Ready, 1);
      chk("tg_no_write", WrEnable, 32'h0);
    end
    Tick = 1;
    cyc();
    Req0Valid = 0;
    chk("tg_write", WrEnable, 32'h200);
    chk("tg_idle", Busy, 0);
    cyc();

    gq.push_back(0);
    Req0Valid = 1; Req0Lock = 1;
    Req0Addr = 10; Req0Data = 32'hA;
    cyc(); cyc();
    Req0Addr = 11; Req0Data = 32'hB;
    chk("mr_beat1", WrEnable, 32'h400);
    chk("mr_locked", Busy, 1);
    #1 Reset = 1'b1;
    #1;
    chk("mr_wren", WrEnable, 32'h0);
    chk("mr_wrdata", WrData, 32'h0);
    chk("mr_busy", Busy, 0);
    chk("mr_rdy0", Req0Ready, 0);
    chk("mr_err", AddrError, 0);
    Req0Valid = 0; Req0Lock = 0;
    cyc();
    Reset = 1'b0;
    chk("mr_no_write", WrEnable, 32'h0);
    gq.push_back(0); gq.push_back(1);
    exp_wr(32'h1000, 32'hC0);
    exp_wr(32'h2000, 32'hD0);
    Req0Valid = 1; Req0Addr = 12; Req0Data = 32'hC0;
    Req1Valid = 1; Req1Addr = 13; Req1Data = 32'hD0;
    cyc();
    chk("mr_tie_p0", Req0Ready, 1);
    cyc();
    Req0Valid = 0;
    cyc();
    chk("mr_then_p1", Req1Ready, 1);
    cyc();
    Req1Valid = 0;
    repeat (3) cyc();

    chk("grant_q_empty", gq.size(), 0);
    chk("write_q_empty", wq.size(), 0);
    $display("%0d/%0d checks passed",
             pass_cnt, total_cnt);
    $finish;
  end

endmodule
